// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 compression sequencer.
// Hash words are packed big-endian: word 0 (H0 / a) lives in [255:224].
package sha256_pkg;

    localparam int WK_LENGTH_DEFAULT = 64;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // FIPS 180-4 initial hash value, H0 in the top word
    localparam logic [255:0] SHA256_H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic word_t hash_word(input logic [255:0] hash, input int unsigned idx);
        return hash[255 - 32*idx -: 32];
    endfunction

endpackage

// File: rtl/sha256_final_adder.sv
// Eight independent 32-bit modular adders forming the Davies-Meyer feed-forward.
// Carries never cross word boundaries.
module sha256_final_adder
    import sha256_pkg::*;
(
    input  logic [255:0] i_hash,
    input  logic [255:0] i_working,
    output logic [255:0] o_sum
);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_word
            assign o_sum[255 - 32*gi -: 32] = hash_word(i_hash, gi) + hash_word(i_working, gi);
        end
    endgenerate

endmodule

// File: rtl/sha256_round_controller.sv
// Sequences one SHA-256 compression: capture hash, load a..h, step rounds
// (stalling on the scheduler), feed-forward add, then hand off the digest.
module sha256_round_controller
    import sha256_pkg::*;
#(
    parameter int WK_LENGTH = WK_LENGTH_DEFAULT,
    localparam int IDX_W    = $clog2(WK_LENGTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_start,
    input  logic [255:0]     i_prev_hash,
    input  logic             i_w_valid,
    input  logic [255:0]     i_working_state,
    input  logic             i_digest_ready,
    output logic             o_load_working,
    output logic [255:0]     o_init_hash,
    output logic             o_round_enable,
    output logic [IDX_W-1:0] o_wk_vector_index,
    output logic             o_wk_index_complete,
    output logic             o_busy,
    output logic [255:0]     o_digest,
    output logic             o_digest_valid
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_LOAD  = ST_LOAD;
    localparam logic [2:0] S_ROUND = ST_ROUND;
    localparam logic [2:0] S_FINAL = ST_FINAL;
    localparam logic [2:0] S_DONE  = ST_DONE;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WK_LENGTH - 1);
    localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(WK_LENGTH);

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_index;
    logic [255:0]     r_init_hash;
    logic [255:0]     r_digest;

    logic [2:0]       w_state_next;
    logic [IDX_W-1:0] w_index_next;
    logic [255:0]     w_init_hash_next;
    logic [255:0]     w_digest_next;
    logic [255:0]     w_sum;
    logic             w_round_enable;

    sha256_final_adder u_final_adder (
        .i_hash    (r_init_hash),
        .i_working (i_working_state),
        .o_sum     (w_sum)
    );

    assign w_round_enable = (r_state == S_ROUND) && i_w_valid;

    always_comb begin
        w_state_next     = r_state;
        w_index_next     = r_index;
        w_init_hash_next = r_init_hash;
        w_digest_next    = r_digest;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_init_hash_next = i_prev_hash;
                    w_index_next     = '0;
                    w_state_next     = S_LOAD;
                end
            end
            S_LOAD:  w_state_next = S_ROUND;
            S_ROUND: begin
                // a stalled cycle (no W word) leaves index and state untouched
                if (w_round_enable) begin
                    w_index_next = r_index + 1'b1;
                    if (r_index == LAST_IDX) begin
                        w_state_next = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                w_digest_next = w_sum;
                w_state_next  = S_DONE;
            end
            S_DONE: begin
                // start is deliberately not looked at here, even on the handshake edge
                if (i_digest_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_init_hash <= '0;
            r_digest    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_index     <= w_index_next;
            r_init_hash <= w_init_hash_next;
            r_digest    <= w_digest_next;
        end
    end

    assign o_load_working      = (r_state == S_LOAD);
    assign o_round_enable      = w_round_enable;
    assign o_wk_vector_index   = r_index;
    // index stays at WK_LENGTH back in IDLE, so qualify with the state
    assign o_wk_index_complete = (r_index == FULL_IDX) && ((r_state == S_FINAL) || (r_state == S_DONE));
    assign o_busy              = (r_state != S_IDLE);
    assign o_init_hash         = r_init_hash;
    assign o_digest            = r_digest;
    assign o_digest_valid      = (r_state == S_DONE);

endmodule

// File: tb/tb_sha256_round_controller.sv
// Directed bench for sha256_round_controller: cycle-exact sequencing,
// feed-forward add, stalls, backpressure, start filtering and reset abort.
module tb_sha256_round_controller;
    import sha256_pkg::*;

    localparam logic [255:0] EXP_2H0 = {
        32'hd413ccce, 32'h76cf5d0a, 32'h78dde6e4, 32'h4a9fea74,
        32'ha21ca4fe, 32'h360ad118, 32'h3f07b356, 32'hb7c19a32
    };
    localparam logic [255:0] ALL_F   = {8{32'hffffffff}};
    localparam logic [255:0] ALL_2   = {8{32'h00000002}};
    localparam logic [255:0] ALL_1   = {8{32'h00000001}};
    localparam logic [255:0] HASH_P2 = {
        32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210,
        32'h0f1e2d3c, 32'h4b5a6978, 32'h8796a5b4, 32'hc3d2e1f0
    };

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [255:0] prev_hash;
    logic         w_valid;
    logic [255:0] working_state;
    logic         digest_ready;
    logic         load_working;
    logic [255:0] init_hash;
    logic         round_enable;
    logic [6:0]   wk_vector_index;
    logic         wk_index_complete;
    logic         busy;
    logic [255:0] digest;
    logic         digest_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    sha256_round_controller dut (
        .clock               (clock),
        .reset               (reset),
        .i_start             (start),
        .i_prev_hash         (prev_hash),
        .i_w_valid           (w_valid),
        .i_working_state     (working_state),
        .i_digest_ready      (digest_ready),
        .o_load_working      (load_working),
        .o_init_hash         (init_hash),
        .o_round_enable      (round_enable),
        .o_wk_vector_index   (wk_vector_index),
        .o_wk_index_complete (wk_index_complete),
        .o_busy              (busy),
        .o_digest            (digest),
        .o_digest_valid      (digest_valid)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".load"},     256'(load_working),      256'(0));
        check({tag, ".round_en"}, 256'(round_enable),      256'(0));
        check({tag, ".complete"}, 256'(wk_index_complete), 256'(0));
        check({tag, ".busy"},     256'(busy),              256'(0));
        check({tag, ".valid"},    256'(digest_valid),      256'(0));
        check({tag, ".index"},    256'(wk_vector_index),   256'(0));
        check({tag, ".init"},     init_hash,               256'(0));
        check({tag, ".digest"},   digest,                  256'(0));
    endtask

    // Runs start..DONE; toggle=1 presents w_valid as 0,1,0,1,... in ROUND.
    task automatic run_block(input string name, input logic [255:0] prev, input logic [255:0] work,
                             input logic [255:0] exp_digest, input bit toggle);
        int n_round_cycles;
        int re_count;
        int cyc;
        n_round_cycles = toggle ? 128 : 64;
        re_count       = 0;
        working_state  = work;
        w_valid        = 1'b0;
        prev_hash      = prev;
        start          = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        #1;
        check({name, ".c1_load"}, 256'(load_working), 256'(1));
        check({name, ".c1_busy"}, 256'(busy),         256'(1));
        check({name, ".c1_idx"},  256'(wk_vector_index), 256'(0));
        check({name, ".c1_init"}, init_hash, prev);
        for (int k = 0; k < n_round_cycles; k++) begin
            tick();
            cyc++;
            w_valid = toggle ? (k % 2 == 1) : 1'b1;
            #1;
            check($sformatf("%s.c%0d_re", name, cyc), 256'(round_enable), 256'(w_valid));
            check($sformatf("%s.c%0d_idx", name, cyc), 256'(wk_vector_index), 256'(toggle ? k / 2 : k));
            check($sformatf("%s.c%0d_cmp", name, cyc), 256'(wk_index_complete), 256'(0));
            check($sformatf("%s.c%0d_val", name, cyc), 256'(digest_valid), 256'(0));
            if (round_enable) re_count++;
        end
        tick();
        cyc++;
        w_valid = 1'b0;
        #1;
        check($sformatf("%s.c%0d_final_cmp", name, cyc), 256'(wk_index_complete), 256'(1));
        check($sformatf("%s.c%0d_final_idx", name, cyc), 256'(wk_vector_index), 256'(64));
        check($sformatf("%s.c%0d_final_val", name, cyc), 256'(digest_valid), 256'(0));
        check($sformatf("%s.c%0d_final_re", name, cyc), 256'(round_enable), 256'(0));
        check({name, ".round_count"}, 256'(re_count), 256'(64));
        tick();
        cyc++;
        check($sformatf("%s.c%0d_valid", name, cyc), 256'(digest_valid), 256'(1));
        check($sformatf("%s.c%0d_digest", name, cyc), digest, exp_digest);
        check($sformatf("%s.c%0d_done_cmp", name, cyc), 256'(wk_index_complete), 256'(1));
        $display("txn %s: digest_valid in cycle %0d digest=%h", name, cyc, digest);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        prev_hash     = '0;
        w_valid       = 1'b0;
        working_state = '0;
        digest_ready  = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;

        // Zero-stall run with the standard IV; working state = IV gives 2*H0 per word
        run_block("h0_zero_stall", SHA256_H0, SHA256_H0, EXP_2H0, 1'b0);
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        check("h0_handshake.busy",     256'(busy),              256'(0));
        check("h0_handshake.valid",    256'(digest_valid),      256'(0));
        check("h0_handshake.complete", 256'(wk_index_complete), 256'(0));
        check("h0_handshake.digest",   digest,                  EXP_2H0);

        // Alternating w_valid; 0xFFFFFFFF + 2 wraps to 1 in every word with no cross-word carry
        run_block("carry_toggle", ALL_F, ALL_2, ALL_1, 1'b1);

        // Backpressure with start pulses during DONE
        prev_hash = HASH_P2;
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            tick();
            check($sformatf("bp%0d.valid", i),  256'(digest_valid), 256'(1));
            check($sformatf("bp%0d.digest", i), digest,             ALL_1);
            check($sformatf("bp%0d.init", i),   init_hash,          ALL_F);
            check($sformatf("bp%0d.load", i),   256'(load_working), 256'(0));
        end

        // start together with the handshake is ignored
        start        = 1'b1;
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        check("b2b_idle.busy", 256'(busy),         256'(0));
        check("b2b_idle.load", 256'(load_working), 256'(0));
        check("b2b_idle.init", init_hash,          ALL_F);
        $display("txn backpressure: digest released after 10 stalled cycles");
        tick();
        start = 1'b0;
        check("b2b_load.load", 256'(load_working),    256'(1));
        check("b2b_load.init", init_hash,             HASH_P2);
        check("b2b_load.idx",  256'(wk_vector_index), 256'(0));

        // Abort mid-ROUND at index 17
        w_valid = 1'b1;
        for (int k = 0; k < 18; k++) tick();
        check("abort.idx17", 256'(wk_vector_index), 256'(17));
        reset = 1'b1;
        tick();
        check_reset_state("abort");
        reset   = 1'b0;
        w_valid = 1'b0;
        $display("txn abort: reset at index 17");

        run_block("after_abort", SHA256_H0, SHA256_H0, EXP_2H0, 1'b0);
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        check("after_abort.idle", 256'(busy), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
